// File: rtl/buf_alloc_ctrl.sv
// buf_alloc_ctrl: 4-entry tagged buffer allocator.
//   A client request (req_vld_i/req_tag_i, accepted while req_rdy_o) is looked
//   up against the 4 entries. On a hit the entry is granted. On a miss the tag
//   is written into the lowest invalid entry. If all entries are valid, a victim
//   is requested from the LFU stage (new_buf_req_o) and taken from
//   buf_num_replc_i. Every grant is a one-cycle pulse on grant_vld_o, mirrored
//   to the LFU stage as a reference report (ref_vld_o/ref_buf_numbr_o).
//   inv_vld_i/inv_buf_i clears one entry's valid bit in any state.
// Ports:
//   clk, rst            clock, async active-high reset
//   req_vld_i/req_tag_i request in,  req_rdy_o accept
//   inv_vld_i/inv_buf_i invalidate one entry
//   grant_vld_o/grant_buf_o/grant_hit_o  grant out
//   new_buf_req_o / buf_num_replc_i      victim handshake with LFU stage
//   ref_vld_o/ref_buf_numbr_o            reference report to LFU stage
module buf_alloc_ctrl #(
  parameter int TAG_W  = 8,
  parameter int FF_DLY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_vld_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             req_rdy_o,
  input  logic             inv_vld_i,
  input  logic [1:0]       inv_buf_i,
  output logic             grant_vld_o,
  output logic [1:0]       grant_buf_o,
  output logic             grant_hit_o,
  output logic             new_buf_req_o,
  input  logic [1:0]       buf_num_replc_i,
  output logic             ref_vld_o,
  output logic [1:0]       ref_buf_numbr_o
);

  // The register update delay is a simulation-only notion; this RTL is
  // zero-delay, so the parameter is kept only for interface compatibility.
  logic unused_ff_dly;
  assign unused_ff_dly = ^FF_DLY;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOK, S_VREQ, S_VWAIT, S_GRANT
  } state_e;

  state_e                     state_q;
  logic [3:0][TAG_W-1:0]      tag_q;
  logic [3:0]                 valid_q;
  logic [TAG_W-1:0]           cur_tag_q;
  logic                       grant_vld_q, grant_hit_q, ref_vld_q, new_buf_req_q;
  logic [1:0]                 grant_buf_q, ref_buf_q;

  // Lookup of the captured tag against the current entries
  logic       hit, free;
  logic [1:0] hit_idx, free_idx;

  always_comb begin
    hit      = 1'b0;
    hit_idx  = 2'd0;
    free     = 1'b0;
    free_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (valid_q[i] && tag_q[i] == cur_tag_q) begin
        hit     = 1'b1;
        hit_idx = 2'(i);
      end
    end
    // Scan downward so the last match is the lowest invalid index
    for (int i = 3; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free     = 1'b1;
        free_idx = 2'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      tag_q         <= '0;
      valid_q       <= '0;
      cur_tag_q     <= '0;
      grant_vld_q   <= 1'b0;
      grant_buf_q   <= 2'd0;
      grant_hit_q   <= 1'b0;
      ref_vld_q     <= 1'b0;
      ref_buf_q     <= 2'd0;
      new_buf_req_q <= 1'b0;
    end else begin
      grant_vld_q   <= 1'b0;
      ref_vld_q     <= 1'b0;
      new_buf_req_q <= 1'b0;
      // Invalidate first; a fill to the same entry below overrides it
      if (inv_vld_i) valid_q[inv_buf_i] <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_vld_i) begin
            cur_tag_q <= req_tag_i;
            state_q   <= S_LOOK;
          end
        end
        S_LOOK: begin
          if (hit) begin
            state_q     <= S_GRANT;
            grant_vld_q <= 1'b1;
            grant_buf_q <= hit_idx;
            grant_hit_q <= 1'b1;
            ref_vld_q   <= 1'b1;
            ref_buf_q   <= hit_idx;
          end else if (free) begin
            tag_q[free_idx]   <= cur_tag_q;
            valid_q[free_idx] <= 1'b1;
            state_q     <= S_GRANT;
            grant_vld_q <= 1'b1;
            grant_buf_q <= free_idx;
            grant_hit_q <= 1'b0;
            ref_vld_q   <= 1'b1;
            ref_buf_q   <= free_idx;
          end else begin
            state_q       <= S_VREQ;
            new_buf_req_q <= 1'b1;
          end
        end
        S_VREQ: state_q <= S_VWAIT;
        S_VWAIT: begin
          tag_q[buf_num_replc_i]   <= cur_tag_q;
          valid_q[buf_num_replc_i] <= 1'b1;
          state_q     <= S_GRANT;
          grant_vld_q <= 1'b1;
          grant_buf_q <= buf_num_replc_i;
          grant_hit_q <= 1'b0;
          ref_vld_q   <= 1'b1;
          ref_buf_q   <= buf_num_replc_i;
        end
        S_GRANT: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_rdy_o       = (state_q == S_IDLE);
  assign grant_vld_o     = grant_vld_q;
  assign grant_buf_o     = grant_buf_q;
  assign grant_hit_o     = grant_hit_q;
  assign ref_vld_o       = ref_vld_q;
  assign ref_buf_numbr_o = ref_buf_q;
  assign new_buf_req_o   = new_buf_req_q;

endmodule

// File: tb/tb_buf_alloc_ctrl.sv
// Self-checking bench for buf_alloc_ctrl: directed scenarios plus random
// traffic against a tag/valid array model of the 4 entries.
module tb_buf_alloc_ctrl;
  logic       clk, rst;
  logic       req_vld_i, req_rdy_o, inv_vld_i;
  logic [7:0] req_tag_i;
  logic [1:0] inv_buf_i, grant_buf_o, buf_num_replc_i, ref_buf_numbr_o;
  logic       grant_vld_o, grant_hit_o, new_buf_req_o, ref_vld_o;

  buf_alloc_ctrl #(.TAG_W(8), .FF_DLY(1)) dut (
    .clk(clk), .rst(rst),
    .req_vld_i(req_vld_i), .req_tag_i(req_tag_i), .req_rdy_o(req_rdy_o),
    .inv_vld_i(inv_vld_i), .inv_buf_i(inv_buf_i),
    .grant_vld_o(grant_vld_o), .grant_buf_o(grant_buf_o), .grant_hit_o(grant_hit_o),
    .new_buf_req_o(new_buf_req_o), .buf_num_replc_i(buf_num_replc_i),
    .ref_vld_o(ref_vld_o), .ref_buf_numbr_o(ref_buf_numbr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  logic [7:0] mtag [4];
  bit         mvalid [4];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin mtag[i] = 8'h00; mvalid[i] = 1'b0; end
  endtask

  // Reset held for one cycle; outputs checked while rst is high.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_rdy", req_rdy_o, 1);
    chk("rst_gvld", grant_vld_o, 0);
    chk("rst_gbuf", grant_buf_o, 0);
    chk("rst_ghit", grant_hit_o, 0);
    chk("rst_nbr", new_buf_req_o, 0);
    chk("rst_rvld", ref_vld_o, 0);
    chk("rst_rbuf", ref_buf_numbr_o, 0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic do_inv(input logic [1:0] k);
    @(negedge clk);
    chk("inv_rdy", req_rdy_o, 1);
    inv_vld_i = 1'b1; inv_buf_i = k;
    mvalid[k] = 1'b0;
    @(negedge clk);
    inv_vld_i = 1'b0;
  endtask

  // One full transaction. inv_at: -1 none, 0 with the accept edge, 1 with the
  // lookup edge. Each cycle's outputs are checked against the model outcome.
  task automatic do_req(input logic [7:0] t, input logic [1:0] replc, input int inv_at,
                        input logic [1:0] inv_idx, output logic [1:0] gb, output logic gh);
    int  hit_k, free_k, idx, gc;
    bit  victim;
    @(negedge clk);
    chk("rdy_idle", req_rdy_o, 1);
    req_vld_i = 1'b1; req_tag_i = t; buf_num_replc_i = replc;
    inv_vld_i = (inv_at == 0); inv_buf_i = inv_idx;
    if (inv_at == 0) mvalid[inv_idx] = 1'b0;
    hit_k = -1; free_k = -1;
    for (int i = 0; i < 4; i++) if (mvalid[i] && mtag[i] == t) hit_k = i;
    for (int i = 3; i >= 0; i--) if (!mvalid[i]) free_k = i;
    victim = 1'b0;
    if (hit_k >= 0)       begin idx = hit_k;  gh = 1'b1; end
    else if (free_k >= 0) begin idx = free_k; gh = 1'b0; end
    else                  begin idx = int'(replc); gh = 1'b0; victim = 1'b1; end
    if (inv_at == 1) mvalid[inv_idx] = 1'b0;
    if (!gh) begin mtag[idx] = t; mvalid[idx] = 1'b1; end
    gc = victim ? 3 : 1;
    @(negedge clk);
    // Busy: random req_vld/tag noise must be ignored
    req_vld_i = 1'($urandom); req_tag_i = 8'($urandom);
    inv_vld_i = (inv_at == 1); inv_buf_i = inv_idx;
    chk("rdy_busy", req_rdy_o, 0);
    chk("gvld_e0", grant_vld_o, 0);
    for (int c = 1; c <= gc + 1; c++) begin
      @(negedge clk);
      inv_vld_i = 1'b0;
      req_vld_i = (c <= gc) ? 1'($urandom) : 1'b0;
      chk("grant_vld", grant_vld_o, (c == gc));
      chk("ref_vld", ref_vld_o, (c == gc));
      chk("new_buf_req", new_buf_req_o, (victim && c == 1));
      chk("req_rdy", req_rdy_o, (c == gc + 1));
      if (c >= gc) begin
        chk("grant_buf", grant_buf_o, idx);
        chk("ref_buf", ref_buf_numbr_o, idx);
        chk("grant_hit", grant_hit_o, gh);
      end
    end
    gb = idx[1:0];
  endtask

  logic [1:0] gb;
  logic       gh;

  initial begin
    rst = 1'b1; req_vld_i = 0; req_tag_i = 0; inv_vld_i = 0; inv_buf_i = 0;
    buf_num_replc_i = 0;
    model_clear();
    do_reset();

    // Fill all four entries
    do_req(8'h11, 2'd0, -1, 2'd0, gb, gh); chk("f11_buf", gb, 0); chk("f11_hit", gh, 0);
    do_req(8'h22, 2'd0, -1, 2'd0, gb, gh); chk("f22_buf", gb, 1); chk("f22_hit", gh, 0);
    do_req(8'h33, 2'd0, -1, 2'd0, gb, gh); chk("f33_buf", gb, 2); chk("f33_hit", gh, 0);
    do_req(8'h44, 2'd0, -1, 2'd0, gb, gh); chk("f44_buf", gb, 3); chk("f44_hit", gh, 0);
    // Hit
    do_req(8'h33, 2'd3, -1, 2'd0, gb, gh); chk("h33_buf", gb, 2); chk("h33_hit", gh, 1);
    // Victim fill then hit
    do_req(8'h55, 2'd1, -1, 2'd0, gb, gh); chk("v55_buf", gb, 1); chk("v55_hit", gh, 0);
    do_req(8'h55, 2'd3, -1, 2'd0, gb, gh); chk("h55_buf", gb, 1); chk("h55_hit", gh, 1);
    // Invalidate then free fill
    do_inv(2'd2);
    do_req(8'h77, 2'd0, -1, 2'd0, gb, gh); chk("f77_buf", gb, 2); chk("f77_hit", gh, 0);
    // Same-edge fill and invalidate of entry 0
    do_inv(2'd0);
    do_req(8'h99, 2'd3, 1, 2'd0, gb, gh); chk("f99_buf", gb, 0); chk("f99_hit", gh, 0);
    do_req(8'h99, 2'd3, -1, 2'd0, gb, gh); chk("h99_buf", gb, 0); chk("h99_hit", gh, 1);
    // Invalidate of the hit entry during lookup does not cancel the hit
    do_req(8'h77, 2'd0, 1, 2'd2, gb, gh); chk("hinv_buf", gb, 2); chk("hinv_hit", gh, 1);
    do_req(8'h77, 2'd0, -1, 2'd0, gb, gh); chk("refill_buf", gb, 2); chk("refill_hit", gh, 0);

    // Reset while waiting on the victim
    @(negedge clk);
    req_vld_i = 1'b1; req_tag_i = 8'hAA; buf_num_replc_i = 2'd2;
    @(negedge clk); req_vld_i = 1'b0;
    @(negedge clk); chk("mr_nbr_hi", new_buf_req_o, 1);
    @(negedge clk); chk("mr_nbr_lo", new_buf_req_o, 0);
    rst = 1'b1; #1;
    chk("mr_gvld", grant_vld_o, 0);
    chk("mr_rdy", req_rdy_o, 1);
    @(negedge clk); rst = 1'b0; model_clear();
    chk("mr_gvld2", grant_vld_o, 0);
    @(negedge clk);
    chk("mr_gvld3", grant_vld_o, 0);
    chk("mr_rdy2", req_rdy_o, 1);
    do_req(8'h44, 2'd3, -1, 2'd0, gb, gh); chk("mr44_buf", gb, 0); chk("mr44_hit", gh, 0);

    // Random traffic over a small tag pool so hits, fills and victims all occur
    for (int n = 0; n < 200; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0) do_inv(2'($urandom));
      else do_req(8'($urandom_range(0, 7)), 2'($urandom),
                  (sel < 4) ? int'($urandom_range(0, 1)) : -1, 2'($urandom), gb, gh);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
